// File: rtl/memreq_q.sv
// memreq_q: in-order memory request FIFO feeding one stall-held read/write issue register.
// Optional MEMREQ_BYPASS_EN: a request accepted into an empty queue with a free slot issues directly.
module memreq_q #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [38:0]  req_addr,
    input  logic [39:0]  req_phy,
    input  logic [532:0] req_data,
    input  logic         stall,
    output logic [38:0]  rdaddr0,
    output logic [39:0]  rdphydata0,
    output logic         rden_in,
    output logic [38:0]  wraddr0,
    output logic [532:0] wrdata,
    output logic         wren_in,
    output logic [15:0]  stall_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic         wr;
        logic [38:0]  addr;
        logic [39:0]  phy;
        logic [532:0] data;
    } req_t;

    req_t          mem [DEPTH];
    req_t          iss;
    req_t          in_req;
    logic          iss_v;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          accept;
    logic          slot_free;
    logic          pop;
    logic          push;
    logic          byp;

    assign in_req    = {req_wr, req_addr, req_phy, req_data};
    // DEPTH is a power of two, so the count MSB alone marks a full queue
    assign req_ready = !count[AW];
    assign accept    = req_valid && req_ready;
    assign slot_free = !iss_v || !stall;
    assign pop       = slot_free && (count != '0);
`ifdef MEMREQ_BYPASS_EN
    assign byp       = slot_free && (count == '0) && accept;
`else
    assign byp       = 1'b0;
`endif
    assign push      = accept && !byp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_req;
    end

    always_ff @(posedge clk) begin
        if (slot_free) iss <= pop ? mem[rp] : in_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            iss_v     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (slot_free) iss_v <= pop || byp;
            if (stall && iss_v && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign rden_in    = iss_v && !iss.wr;
    assign wren_in    = iss_v && iss.wr;
    assign rdaddr0    = rden_in ? iss.addr : '0;
    assign rdphydata0 = rden_in ? iss.phy : '0;
    assign wraddr0    = wren_in ? iss.addr : '0;
    assign wrdata     = wren_in ? iss.data : '0;
endmodule

// File: tb/tb_memreq_q.sv
// tb_memreq_q: randomized request streams checked against a transaction queue model of memreq_q.
module tb_memreq_q;
    localparam int DEPTH = 4;
`ifdef MEMREQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    typedef logic [652:0] ovec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_wr = 1'b0;
    logic [38:0]  req_addr = '0;
    logic [39:0]  req_phy = '0;
    logic [532:0] req_data = '0;
    logic         stall = 1'b0;
    logic         req_ready;
    logic         rden_in;
    logic         wren_in;
    logic [38:0]  rdaddr0;
    logic [38:0]  wraddr0;
    logic [39:0]  rdphydata0;
    logic [532:0] wrdata;
    logic [15:0]  stall_cnt;
    ovec_t        obs;

    int    vectors = 0;
    int    errors = 0;
    int    issued = 0;
    int    model_cnt = 0;
    ovec_t exp_q[$];
    logic  held_v = 1'b0;
    ovec_t held;

    memreq_q #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_phy(req_phy), .req_data(req_data),
        .stall(stall), .rdaddr0(rdaddr0), .rdphydata0(rdphydata0), .rden_in(rden_in),
        .wraddr0(wraddr0), .wrdata(wrdata), .wren_in(wren_in), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    assign obs = {rden_in, rdaddr0, rdphydata0, wren_in, wraddr0, wrdata};

    function automatic ovec_t req_vec(input logic wr, input logic [38:0] a, input logic [39:0] p, input logic [532:0] d);
        return wr ? {1'b0, 39'b0, 40'b0, 1'b1, a, d} : {1'b1, a, p, 1'b0, 39'b0, 533'b0};
    endfunction

    // Every issue consumed downstream must be the oldest outstanding accepted request.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_cnt = 0;
            held_v = 1'b0;
        end else begin
            vectors++;
            if (stall_cnt !== 16'(model_cnt)) begin
                errors++;
                $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, model_cnt);
            end
            vectors++;
            if (rden_in && wren_in) begin
                errors++;
                $display("FAIL both_en: rden=%b wren=%b want not both", rden_in, wren_in);
            end
            if (held_v) begin
                vectors++;
                if (obs !== held) begin
                    errors++;
                    $display("FAIL hold: got %h want %h", obs, held);
                end
            end
            if (!rden_in && !wren_in) begin
                vectors++;
                if (obs !== '0) begin
                    errors++;
                    $display("FAIL idle_out: got %h want 0", obs);
                end
            end else if (!stall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stale_issue: got %h want no issue", obs);
                end else begin
                    if (obs !== exp_q[0]) begin
                        errors++;
                        $display("FAIL order: got %h want %h", obs, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                issued++;
            end
            held_v = (rden_in || wren_in) && stall;
            held = obs;
            if (stall && (rden_in || wren_in) && model_cnt < 65535) model_cnt++;
            if (req_valid && req_ready) exp_q.push_back(req_vec(req_wr, req_addr, req_phy, req_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req();
        logic [543:0] d;
        logic [63:0]  a;
        logic [63:0]  p;
        for (int i = 0; i < 17; i++) d[i*32 +: 32] = $urandom;
        a = {$urandom, $urandom};
        p = {$urandom, $urandom};
        req_wr = 1'($urandom_range(0, 1));
        req_addr = a[38:0];
        req_phy = p[39:0];
        req_data = d[532:0];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (req_ready !== 1'b1 || obs !== '0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: ready=%b out_nonzero=%b cnt=%0d want 1 0 0", req_ready, |obs, stall_cnt);
        end
    endtask

    task automatic test_single_read();
        logic [39:0] p;
        p = {$urandom, 8'h5a};
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = 39'h12345;
        req_phy = p;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            vectors++;
            if (rden_in !== (i == LAT) || wren_in !== 1'b0 ||
                (i == LAT && (rdaddr0 !== 39'h12345 || rdphydata0 !== p))) begin
                errors++;
                $display("FAIL single_read edge %0d: rden=%b addr=%h want rden=%b addr=12345", i, rden_in, rdaddr0, i == LAT);
            end
            if (i <= LAT) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [38:0]  wa;
        logic [38:0]  ra;
        logic [532:0] wd;
        rand_req();
        req_wr = 1'b1;
        req_valid = 1'b1;
        wa = req_addr;
        wd = req_data;
        ra = '0;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            if (e == 1) begin
                rand_req();
                req_wr = 1'b0;
                ra = req_addr;
            end else begin
                req_valid = 1'b0;
            end
            vectors++;
            if (wren_in !== (e == LAT) || rden_in !== (e == LAT + 1)) begin
                errors++;
                $display("FAIL b2b_seq edge %0d: wren=%b rden=%b want %b %b", e, wren_in, rden_in, e == LAT, e == LAT + 1);
            end
            if (e == LAT) begin
                vectors++;
                if (wraddr0 !== wa || wrdata !== wd) begin
                    errors++;
                    $display("FAIL b2b_write: addr=%h want %h", wraddr0, wa);
                end
            end
            if (e == LAT + 1) begin
                vectors++;
                if (rdaddr0 !== ra) begin
                    errors++;
                    $display("FAIL b2b_read: addr=%h want %h", rdaddr0, ra);
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        int n;
        do_reset();
        rand_req();
        req_valid = 1'b1;
        tick();
        rand_req();
        tick();
        stall = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_req();
            tick();
        end
        vectors++;
        if (stall_cnt !== 16'd10 || req_ready !== 1'b0 || (rden_in || wren_in) !== 1'b1) begin
            errors++;
            $display("FAIL stall_fill: cnt=%0d ready=%b active=%b want 10 0 1", stall_cnt, req_ready, rden_in || wren_in);
        end
        vectors++;
        if (exp_q.size() != DEPTH + 1) begin
            errors++;
            $display("FAIL stall_fill_outstanding: got %0d want %0d", exp_q.size(), DEPTH + 1);
        end
        stall = 1'b0;
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_fill_drain: left %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_stall_toggle();
        int acc;
        int base;
        int n;
        do_reset();
        acc = 0;
        base = issued;
        rand_req();
        req_valid = 1'b1;
        for (int c = 0; c < 100 && acc < 8; c++) begin
            if (req_ready) acc++;
            tick();
            stall = ~stall;
            if (acc < 8) rand_req();
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            stall = ~stall;
            n++;
        end
        stall = 1'b0;
        tick();
        tick();
        vectors++;
        if (acc != 8 || exp_q.size() != 0 || issued - base != 8) begin
            errors++;
            $display("FAIL stall_toggle: accepted=%0d left=%0d issued=%0d want 8 0 8", acc, exp_q.size(), issued - base);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rand_req();
            tick();
        end
        req_valid = 1'b0;
        vectors++;
        if ((rden_in || wren_in) !== 1'b1 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL reset_mid_setup: active=%b outstanding=%0d want 1 4", rden_in || wren_in, exp_q.size());
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== '0 || req_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: out_nonzero=%b ready=%b cnt=%0d want 0 1 0", |obs, req_ready, stall_cnt);
        end
        stall = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if ((rden_in || wren_in) !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_stale: rden=%b wren=%b want 0 0", rden_in, wren_in);
            end
        end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        rand_req();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!(rden_in || wren_in) && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if ((rden_in || wren_in) !== 1'b1) begin
            errors++;
            $display("FAIL sat_issue_timeout: active=%b want 1", rden_in || wren_in);
        end
        stall = 1'b1;
        for (int c = 0; c < 65534; c++) tick();
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: got %h want fffe", stall_cnt);
        end
        for (int c = 0; c < 70000 - 65534; c++) tick();
        vectors++;
        if (stall_cnt !== 16'hFFFF || (rden_in || wren_in) !== 1'b1) begin
            errors++;
            $display("FAIL sat: got %h active=%b want ffff 1", stall_cnt, rden_in || wren_in);
        end
        stall = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_stall_fill();
        test_stall_toggle();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
